// File: rtl/boron_cipher_core.sv
// Iterative BORON block cipher core: encrypt/decrypt, 80/128-bit key, UNROLL rounds per clock.
// Ready/valid on both sides; decrypt runs the key schedule forward before unwinding the rounds.
module boron_cipher_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 25,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [63:0]      in_block,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_block,
  output logic             busy
);

  if (!((KEY_W == 80) || (KEY_W == 128)) || (UNROLL < 1) || ((ROUNDS % UNROLL) != 0)) begin : g_bad_param
    $error("boron_cipher_core: illegal KEY_W or UNROLL");
  end

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST_UP = CW'(ROUNDS - UNROLL);
  localparam logic [CW-1:0] LAST_DN = CW'(UNROLL - 1);
  localparam logic [CW-1:0] TOP_RND = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] STEP    = CW'(UNROLL);

  // Nibble x of the table holds S(x) / S^-1(x).
  localparam logic [63:0] SBOX_T  = 64'h6358_F02D_AC97_1B4E;
  localparam logic [63:0] ISBOX_T = 64'hB086_275C_4FD1_E93A;

  typedef enum logic [2:0] {IDLE, KEYEXP, ROUND, FINAL, OUT} state_t;

  state_t             r_state, w_next;
  logic [63:0]        r_s;
  logic [KEY_W-1:0]   r_key;
  logic [CW-1:0]      r_cnt;
  logic               r_dec;
  logic [63:0]        r_out_block;
  logic               r_out_valid;
  logic [63:0]        w_s_enc, w_s_dec;
  logic [KEY_W-1:0]   w_k_enc, w_k_dec;
  logic               w_last_up, w_last_dn;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_T[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return ISBOX_T[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s, input logic inv);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[i*4 +: 4] = inv ? inv_sbox(s[i*4 +: 4]) : sbox(s[i*4 +: 4]);
    return o;
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int n);
    return (w << n) | (w >> (16 - n));
  endfunction

  function automatic logic [63:0] block_shuffle(input logic [63:0] s);
    return {s[47:32], s[15:0], s[63:48], s[31:16]};
  endfunction

  function automatic logic [63:0] inv_block_shuffle(input logic [63:0] s);
    return {s[31:16], s[63:48], s[15:0], s[47:32]};
  endfunction

  function automatic logic [63:0] round_permutation(input logic [63:0] s);
    return {rotl16(s[63:48], 9), rotl16(s[47:32], 7), rotl16(s[31:16], 4), rotl16(s[15:0], 1)};
  endfunction

  function automatic logic [63:0] inv_round_permutation(input logic [63:0] s);
    return {rotl16(s[63:48], 7), rotl16(s[47:32], 9), rotl16(s[31:16], 12), rotl16(s[15:0], 15)};
  endfunction

  function automatic logic [63:0] xor_operation(input logic [63:0] s);
    logic [15:0] t3, t2, t1, t0;
    t3 = s[63:48] ^ s[31:16];
    t2 = s[47:32] ^ s[15:0];
    t1 = s[31:16] ^ t2;
    t0 = s[15:0]  ^ t3;
    return {t3, t2, t1, t0};
  endfunction

  function automatic logic [63:0] inv_xor_operation(input logic [63:0] s);
    logic [15:0] w3, w2, w1, w0;
    w1 = s[31:16] ^ s[47:32];
    w0 = s[15:0]  ^ s[63:48];
    w3 = s[63:48] ^ w1;
    w2 = s[47:32] ^ w0;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [KEY_W-1:0] enc_key_scheduler(input logic [4:0] rc, input logic [KEY_W-1:0] k);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
    t[3:0] = sbox(t[3:0]);
    if (KEY_W == 128) t[7:4] = sbox(t[7:4]);
    t[63:59] = t[63:59] ^ rc;
    return t;
  endfunction

  function automatic logic [KEY_W-1:0] dec_key_scheduler(input logic [4:0] rc, input logic [KEY_W-1:0] k);
    logic [KEY_W-1:0] t;
    t = k;
    t[63:59] = t[63:59] ^ rc;
    t[3:0] = inv_sbox(t[3:0]);
    if (KEY_W == 128) t[7:4] = inv_sbox(t[7:4]);
    return {t[12:0], t[KEY_W-1:13]};
  endfunction

  // Unrolled round chains; instance j uses round index r_cnt+j (encrypt) or r_cnt-j (decrypt).
  always_comb begin
    w_s_enc = r_s;
    w_k_enc = r_key;
    w_s_dec = r_s;
    w_k_dec = r_key;
    for (int j = 0; j < UNROLL; j++) begin
      w_s_enc = xor_operation(round_permutation(block_shuffle(sbox_layer(w_s_enc ^ w_k_enc[63:0], 1'b0))));
      w_k_enc = enc_key_scheduler(5'(int'(r_cnt) + j), w_k_enc);
    end
    for (int j = 0; j < UNROLL; j++) begin
      w_k_dec = dec_key_scheduler(5'(int'(r_cnt) - j), w_k_dec);
      w_s_dec = sbox_layer(inv_block_shuffle(inv_round_permutation(inv_xor_operation(w_s_dec))), 1'b1)
                ^ w_k_dec[63:0];
    end
  end

  assign w_last_up = (r_cnt == LAST_UP);
  assign w_last_dn = (r_cnt == LAST_DN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = in_decrypt ? KEYEXP : ROUND;
      KEYEXP:  if (w_last_up) w_next = ROUND;
      ROUND: begin
        if (r_dec && w_last_dn)       w_next = OUT;
        else if (!r_dec && w_last_up) w_next = FINAL;
      end
      FINAL:   w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s         <= '0;
      r_key       <= '0;
      r_cnt       <= '0;
      r_dec       <= 1'b0;
      r_out_block <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s   <= in_block;
            r_key <= in_key;
            r_dec <= in_decrypt;
            r_cnt <= '0;
          end
        end
        KEYEXP: begin
          r_key <= w_k_enc;
          if (w_last_up) begin
            r_s   <= r_s ^ w_k_enc[63:0];
            r_cnt <= TOP_RND;
          end else begin
            r_cnt <= r_cnt + STEP;
          end
        end
        ROUND: begin
          if (r_dec) begin
            r_s   <= w_s_dec;
            r_key <= w_k_dec;
            r_cnt <= r_cnt - STEP;
            if (w_last_dn) begin
              r_out_block <= w_s_dec;
              r_out_valid <= 1'b1;
            end
          end else begin
            r_s   <= w_s_enc;
            r_key <= w_k_enc;
            r_cnt <= r_cnt + STEP;
          end
        end
        FINAL: begin
          r_out_block <= r_s ^ r_key[63:0];
          r_out_valid <= 1'b1;
        end
        OUT: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_block = r_out_block;

endmodule

// File: tb/tb_boron_cipher_core.sv
// Bench for boron_cipher_core: 80-bit/UNROLL=1, 128-bit/UNROLL=1 and 80-bit/UNROLL=5 instances
// checked against a reference model through a scoreboard queue.
module tb_boron_cipher_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid[3], in_ready[3], in_decrypt[3], out_valid[3], out_ready[3], busy[3];
  logic [63:0] in_block[3], out_block[3];
  logic [127:0] in_key[3];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  logic [63:0] sb_q[$];

  localparam logic [3:0] SB[16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  localparam int ROT[4] = '{1, 4, 7, 9};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boron_cipher_core #(.KEY_W(80), .ROUNDS(25), .UNROLL(1)) u_k80 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_decrypt(in_decrypt[0]), .in_block(in_block[0]), .in_key(in_key[0][79:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_block(out_block[0]), .busy(busy[0]));

  boron_cipher_core #(.KEY_W(128), .ROUNDS(25), .UNROLL(1)) u_k128 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_decrypt(in_decrypt[1]), .in_block(in_block[1]), .in_key(in_key[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_block(out_block[1]), .busy(busy[1]));

  boron_cipher_core #(.KEY_W(80), .ROUNDS(25), .UNROLL(5)) u_u5 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_decrypt(in_decrypt[2]), .in_block(in_block[2]), .in_key(in_key[2][79:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_block(out_block[2]), .busy(busy[2]));

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_sbl(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    logic [3:0]  nib;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      nib = s[i*4 +: 4];
      if (!inv) o[i*4 +: 4] = SB[nib];
      else for (int v = 0; v < 16; v++) if (SB[v] == nib) o[i*4 +: 4] = 4'(v);
    end
    return o;
  endfunction

  function automatic logic [63:0] m_perm(input logic [63:0] s);
    logic [15:0] w[4], b[4], r[4], x[4];
    for (int k = 0; k < 4; k++) w[k] = s[16*k +: 16];
    b[3] = w[2]; b[2] = w[0]; b[1] = w[3]; b[0] = w[1];
    for (int k = 0; k < 4; k++) r[k] = (b[k] << ROT[k]) | (b[k] >> (16 - ROT[k]));
    x[3] = r[3] ^ r[1]; x[2] = r[2] ^ r[0]; x[1] = r[1] ^ x[2]; x[0] = r[0] ^ x[3];
    return {x[3], x[2], x[1], x[0]};
  endfunction

  function automatic logic [63:0] m_iperm(input logic [63:0] s);
    logic [15:0] w[4], b[4], r[4], x[4];
    for (int k = 0; k < 4; k++) x[k] = s[16*k +: 16];
    r[1] = x[1] ^ x[2]; r[0] = x[0] ^ x[3]; r[3] = x[3] ^ r[1]; r[2] = x[2] ^ r[0];
    for (int k = 0; k < 4; k++) b[k] = (r[k] >> ROT[k]) | (r[k] << (16 - ROT[k]));
    w[2] = b[3]; w[0] = b[2]; w[3] = b[1]; w[1] = b[0];
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [127:0] m_ks(input int rc, input logic [127:0] k, input int kw);
    logic [127:0] n;
    logic [4:0]   rc5;
    n = '0;
    rc5 = 5'(rc);
    for (int i = 0; i < kw; i++) n[(i + 13) % kw] = k[i];
    n[3:0] = SB[n[3:0]];
    if (kw == 128) n[7:4] = SB[n[7:4]];
    n[63:59] = n[63:59] ^ rc5;
    return n;
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [127:0] key, input int kw);
    logic [63:0]  s;
    logic [127:0] k;
    s = p; k = key;
    for (int r = 0; r < 25; r++) begin
      s = m_perm(m_sbl(s ^ k[63:0], 1'b0));
      k = m_ks(r, k, kw);
    end
    return s ^ k[63:0];
  endfunction

  function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [127:0] key, input int kw);
    logic [127:0] ka[26];
    logic [63:0]  s;
    ka[0] = key;
    for (int r = 0; r < 25; r++) ka[r+1] = m_ks(r, ka[r], kw);
    s = c ^ ka[25][63:0];
    for (int r = 24; r >= 0; r--) s = m_sbl(m_iperm(s), 1'b1) ^ ka[r][63:0];
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_txn(input int d, input logic dec, input logic [63:0] blk,
                           input logic [127:0] key, input logic rdy, input string nm, output int acc);
    @(negedge clk);
    in_valid[d] = 1'b1; in_decrypt[d] = dec; in_block[d] = blk; in_key[d] = key; out_ready[d] = rdy;
    chk({nm, "_in_ready_pre"}, in_ready[d], 1);
    @(posedge clk); #1;
    acc = cyc;
    in_valid[d] = 1'b0; in_decrypt[d] = ~dec; in_block[d] = ~blk; in_key[d] = ~key;
  endtask

  task automatic wait_out(input int d, input int acc, input int lat_exp, input string nm,
                          output logic [63:0] got);
    bit          seen;
    logic [63:0] exp;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (out_valid[d]) seen = 1'b1;
    end
    chk({nm, "_timeout"}, seen, 1);
    chk({nm, "_latency"}, cyc - acc, lat_exp);
    exp = sb_q.pop_front();
    got = out_block[d];
    chk({nm, "_block"}, got, exp);
  endtask

  task automatic finish_hs(input int d, input string nm);
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, out_valid[d], 0);
    chk({nm, "_in_ready_post"}, in_ready[d], 1);
    chk({nm, "_busy_post"}, busy[d], 0);
  endtask

  task automatic run_txn(input int d, input logic dec, input logic [63:0] blk, input logic [127:0] key,
                         input logic [63:0] exp, input int lat, input string nm, output logic [63:0] got);
    int acc;
    sb_q.push_back(exp);
    start_txn(d, dec, blk, key, 1'b1, nm, acc);
    wait_out(d, acc, lat, nm, got);
    finish_hs(d, nm);
  endtask

  typedef struct {
    int           d;
    logic         dec;
    logic [63:0]  blk;
    logic [127:0] key;
    logic [63:0]  exp;
    int           lat;
    string        nm;
  } vec_t;

  function automatic vec_t mkv(input int d, input logic dec, input logic [63:0] blk,
                               input logic [127:0] key, input int kw, input int lat, input string nm);
    vec_t v;
    v.d = d; v.dec = dec; v.blk = blk; v.key = key; v.lat = lat; v.nm = nm;
    v.exp = dec ? m_dec(blk, key, kw) : m_enc(blk, key, kw);
    return v;
  endfunction

  localparam logic [127:0] K80_ONES  = {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
  localparam logic [127:0] K128_ONES = {128{1'b1}};
  localparam logic [63:0]  PT        = 64'h0123_4567_89AB_CDEF;

  initial begin
    vec_t        tv[8];
    logic [63:0] got, c, exp, blk;
    logic [127:0] key;
    logic        dec;
    int          acc;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 0; in_decrypt[d] = 0; in_block[d] = '0; in_key[d] = '0; out_ready[d] = 0;
    end
    #2;
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_out_block", out_block[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_in_ready", in_ready[0], 1);
    #10 reset = 1'b0;

    tv[0] = mkv(0, 1'b0, 64'h0, 128'h0, 80, 26, "enc80_zero");
    tv[1] = mkv(0, 1'b0, PT, K80_ONES, 80, 26, "enc80_pt");
    tv[2] = mkv(1, 1'b0, PT, K128_ONES, 128, 26, "enc128_pt");
    tv[3] = mkv(0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, {48'h0, 80'h1234_5678_9ABC_DEF0_1357}, 80, 50, "dec80");
    tv[4] = mkv(1, 1'b1, 64'h0F1E_2D3C_4B5A_6978, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 128, 50, "dec128");
    tv[5] = mkv(2, 1'b0, PT, K80_ONES, 80, 6, "enc80_u5");
    tv[6] = mkv(2, 1'b1, PT, K80_ONES, 80, 10, "dec80_u5");
    tv[7] = mkv(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0, 128, 26, "enc128_ones");
    for (int i = 0; i < 8; i++) run_txn(tv[i].d, tv[i].dec, tv[i].blk, tv[i].key, tv[i].exp, tv[i].lat, tv[i].nm, got);

    run_txn(0, 1'b0, PT, K80_ONES, m_enc(PT, K80_ONES, 80), 26, "rt80_enc", c);
    run_txn(0, 1'b1, c, K80_ONES, PT, 50, "rt80_dec", got);
    run_txn(1, 1'b0, PT, K128_ONES, m_enc(PT, K128_ONES, 128), 26, "rt128_enc", c);
    run_txn(1, 1'b1, c, K128_ONES, PT, 50, "rt128_dec", got);

    // Backpressure: result must hold while out_ready is low.
    sb_q.push_back(m_enc(PT, K80_ONES, 80));
    start_txn(0, 1'b0, PT, K80_ONES, 1'b0, "bp", acc);
    wait_out(0, acc, 26, "bp", got);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid[0], 1);
      chk("bp_hold_block", out_block[0], got);
      chk("bp_hold_in_ready", in_ready[0], 0);
    end
    finish_hs(0, "bp");

    // A second in_valid mid-ROUND must be ignored.
    sb_q.push_back(m_enc(64'hAAAA_5555_AAAA_5555, K80_ONES, 80));
    start_txn(0, 1'b0, 64'hAAAA_5555_AAAA_5555, K80_ONES, 1'b1, "busy_ign", acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b1; in_block[0] = 64'h1111_2222_3333_4444; in_decrypt[0] = 1'b1;
    chk("busy_ign_in_ready", in_ready[0], 0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_out(0, acc, 26, "busy_ign", got);
    finish_hs(0, "busy_ign");

    // Asynchronous reset in the middle of the rounds.
    start_txn(0, 1'b0, PT, K80_ONES, 1'b1, "rst_mid", acc);
    repeat (10) @(posedge clk);
    #3;
    chk("rst_mid_busy_before", busy[0], 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_in_ready", in_ready[0], 1);
    reset = 1'b0;
    run_txn(0, 1'b0, 64'h0BAD_CAFE_1234_5678, K80_ONES, m_enc(64'h0BAD_CAFE_1234_5678, K80_ONES, 80),
            26, "rst_after", got);

    // UNROLL=5 random vectors.
    for (int i = 0; i < 100; i++) begin
      dec = 1'($urandom_range(0, 1));
      blk = {$urandom, $urandom};
      key = {48'h0, 16'($urandom), $urandom, $urandom};
      exp = dec ? m_dec(blk, key, 80) : m_enc(blk, key, 80);
      run_txn(2, dec, blk, key, exp, dec ? 10 : 6, dec ? "u5_dec" : "u5_enc", got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
